wb_stage: RTL
=============

// Module: wb_stage
// PURPOSE
//  MEM/WB pipeline register and writeback stage of the 5-stage RV32I pipeline; sits directly upstream of the register file.
//  Captures MEM-stage results, aligns and sign/zero-extends load data from the synchronous data memory, and selects the writeback source.
//  Drives the register-file write port (wb_en/rd_index/wb_data) and the WB forwarding path, and counts retired instructions.
// PARAMETERS
//  XLEN   32  datapath width
//  CNT_W  64  width of retired-instruction counter
// PORTS
//  clk            in   1      clock; all state updates on posedge
//  rst            in   1      synchronous, active-high reset
//  stall          in   1      hold MEM/WB register contents
//  flush          in   1      load a bubble into MEM/WB; overrides stall
//  mem_valid      in   1      MEM stage holds a real instruction
//  mem_wb_en      in   1      instruction writes rd
//  mem_rd_index   in   5      destination register
//  mem_wb_sel     in   2      00 ALU, 01 load, 10 PC+4, 11 ALU
//  mem_funct3     in   3      load width/sign code
//  mem_alu_result in   XLEN   ALU result; also the load address
//  mem_pc_plus4   in   XLEN   link value for JAL/JALR
//  dm_rdata       in   XLEN   data-memory read word, valid in the instruction's first WB cycle
//  wb_en          out  1      register-file write enable
//  rd_index       out  5      register-file write index
//  wb_data        out  XLEN   register-file write data
//  wb_valid       out  1      WB holds a real instruction (for hazard/forwarding units)
//  instret        out  CNT_W  retired-instruction count
// BEHAVIOUR
//  Reset: valid_q, wb_en_q, rd_q, sel_q, f3_q, alu_q, pc4_q, first_q, ld_hold_q and instret all 0.
//   Outputs are therefore wb_en=0, rd_index=0, wb_data=0, wb_valid=0 and instret=0.
//  Register update priority: rst > flush > stall > capture.
//   flush: valid_q<=0 and first_q<=0; other fields are don't-care.
//   stall (no flush): all fields hold.
//   capture: all mem_* fields are latched; valid_q<=mem_valid; first_q<=1.
//  first_q is cleared on any cycle where WB holds (stall & ~flush).
//   While first_q=1, the load value comes from dm_rdata and is latched into ld_hold_q at the clock edge.
//   While first_q=0 (stalled repeat cycles), the load value comes from ld_hold_q.
//   dm_rdata is not required to stay stable across a stall.
//  Load extraction is little-endian, using byte offset a=alu_q[1:0]:
//   LB  (000): sext(byte[a])
//   LH  (001): sext(half[a[1]]); a[0] is ignored
//   LW  (010): word as-is; a is ignored
//   LBU (100): zext(byte[a])
//   LHU (101): zext(half[a[1]])
//   other codes: word as-is
//  wb_data: selected per sel_q; combinational from registered state and dm_rdata. It is 0 when valid_q=0.
//  wb_en = valid_q & wb_en_q & (rd_q!=0). rd_index = rd_q.
//   Repeated writes during a stall are allowed; the written value is identical.
//  wb_valid = valid_q.
//  Retire: instret += 1 on a posedge where valid_q & (flush | ~stall), i.e. the instruction leaves WB.
//   Each instruction is counted exactly once. The counter wraps modulo 2^CNT_W.
//  Latency: one cycle from MEM signals to WB outputs.
//  A reset asserted mid-stall discards the held instruction; it is not counted.
// STRUCTURE
//  rv_pkg: WB_SEL_ALU/LOAD/PC4 constants and F3_LB/LH/LW/LBU/LHU load codes. Shared with decoder and MEM stage.
//  Sub-module load_extend (combinational): inputs word, addr[1:0], funct3; output XLEN. Reused by any future cache.
//  Everything else is inline: the pipeline register, first_q/ld_hold_q, the writeback mux and the counter.
// TESTING
//  ALU op, rd=5, result 0x1234_5678 -> next cycle wb_en=1, rd_index=5, wb_data=0x1234_5678; instret=1 one cycle later.
//  LB, addr 0x..03, dm_rdata=0x80FF_1122 -> wb_data=0xFFFF_FF80. LBU same -> 0x0000_0080. LH, addr 0x..02 -> 0xFFFF_80FF.
//  LW captured, then 3-cycle stall with dm_rdata changed to 0xDEAD_BEEF -> wb_data holds the original word; instret +1 only.
//  rd=0 with mem_wb_en=1 -> wb_en=0 while wb_valid=1; JAL with sel=10, pc+4=0x104 -> wb_data=0x104.
//  flush and stall asserted together -> bubble enters (wb_valid=0 next cycle); the WB instruction retires once.
//  rst pulsed during a stall with a valid load in WB -> all outputs 0 next cycle; instret=0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I pipeline constants: writeback source selects and load funct3 codes.
package rv_pkg;

   localparam logic [1:0] WB_SEL_ALU  = 2'b00;
   localparam logic [1:0] WB_SEL_LOAD = 2'b01;
   localparam logic [1:0] WB_SEL_PC4  = 2'b10;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_load_extend.sv
// Little-endian load alignment and sign/zero extension of a 32-bit memory word.
module load_extend
   import rv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] word,
   input  logic [1:0]      addr,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed byte/half, then extend according to the load code.
   always_comb begin
      byte_sel = word[{addr, 3'b000} +: 8];
      half_sel = addr[1] ? word[31:16] : word[15:0];
      case (funct3)
         F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
         F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
         F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
         F3_LW:   data = word;
         default: data = word;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback stage: load alignment, writeback mux,
// register-file write port and retired-instruction counter.
module wb_stage
   import rv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             flush,
   input  logic             mem_valid,
   input  logic             mem_wb_en,
   input  logic [4:0]       mem_rd_index,
   input  logic [1:0]       mem_wb_sel,
   input  logic [2:0]       mem_funct3,
   input  logic [XLEN-1:0]  mem_alu_result,
   input  logic [XLEN-1:0]  mem_pc_plus4,
   input  logic [XLEN-1:0]  dm_rdata,
   output logic             wb_en,
   output logic [4:0]       rd_index,
   output logic [XLEN-1:0]  wb_data,
   output logic             wb_valid,
   output logic [CNT_W-1:0] instret
);

   logic            valid_q, wb_en_q, first_q;
   logic [4:0]      rd_q;
   logic [1:0]      sel_q;
   logic [2:0]      f3_q;
   logic [XLEN-1:0] alu_q, pc4_q, ld_hold_q;
   logic [XLEN-1:0] ld_word, ld_data;

   // MEM/WB register: flush beats stall beats capture; first_q marks the
   // first WB cycle, the only one where dm_rdata is guaranteed to be valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         wb_en_q <= 1'b0;
         rd_q    <= '0;
         sel_q   <= '0;
         f3_q    <= '0;
         alu_q   <= '0;
         pc4_q   <= '0;
         first_q <= 1'b0;
      end else if (flush) begin
         valid_q <= 1'b0;
         first_q <= 1'b0;
      end else if (stall) begin
         first_q <= 1'b0;
      end else begin
         valid_q <= mem_valid;
         wb_en_q <= mem_wb_en;
         rd_q    <= mem_rd_index;
         sel_q   <= mem_wb_sel;
         f3_q    <= mem_funct3;
         alu_q   <= mem_alu_result;
         pc4_q   <= mem_pc_plus4;
         first_q <= 1'b1;
      end
   end

   // Keep the load word from the first WB cycle so stalled repeats see the same value.
   always_ff @(posedge clk) begin
      if (rst)          ld_hold_q <= '0;
      else if (first_q) ld_hold_q <= dm_rdata;
   end

   // Count an instruction when it leaves WB (flushed out or advanced).
   always_ff @(posedge clk) begin
      if (rst)                            instret <= '0;
      else if (valid_q && (flush || !stall)) instret <= instret + CNT_W'(1);
   end

   assign ld_word = first_q ? dm_rdata : ld_hold_q;

   load_extend #(.XLEN(XLEN)) u_load_extend (
      .word   (ld_word),
      .addr   (alu_q[1:0]),
      .funct3 (f3_q),
      .data   (ld_data)
   );

   // Writeback source select; bubbles drive zero data.
   always_comb begin
      wb_data = '0;
      if (valid_q) begin
         case (sel_q)
            WB_SEL_LOAD: wb_data = ld_data;
            WB_SEL_PC4:  wb_data = pc4_q;
            default:     wb_data = alu_q;
         endcase
      end
   end

   assign wb_en    = valid_q & wb_en_q & (rd_q != 5'd0);
   assign rd_index = rd_q;
   assign wb_valid = valid_q;

endmodule
